nibble_serial_alu: RTL and testbench
====================================

# nibble_serial_alu

Multi-cycle sequencer that performs wide (4·NIB-bit) arithmetic by streaming 4-bit slices, least-significant nibble first, through a 4-bit operand-conditioning and add stage, one nibble per clock. The carry is chained from one slice to the next. It sits on the issuing side of the 4-bit ALU datapath. It accepts a wide operation request, produces the per-nibble conditioned operands and carry-in, collects the 4-bit sums, and returns the wide result with flags through a start/busy/done handshake.

## Interface
- NIB, default 4: number of 4-bit slices; operand width W = 4·NIB; legal range 2..8.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00 ADD A+B, 01 SUB A−B, 10 INC A+1, 11 NEG −A.
- a  input  W  operand A, sampled with start.
- b  input  W  operand B, sampled with start; ignored for INC/NEG.
- busy  output  1  high from the edge after accepted start until the last nibble is done.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle onward.
- result  output  W  wide result, two's complement.
- cout  output  1  carry out of the MSB; for SUB, 1 means no borrow.
- zero  output  1  result == 0.
- ovf  output  1  signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async, reset=0):
  - State goes to IDLE.
  - busy=0, done=0, result=0, cout=0, zero=0, ovf=0.
  - Nibble counter, carry and shift registers all cleared.
- IDLE:
  - On start=1, latch a, b and op into shift registers.
  - Set counter=0 and load the carry register with the op's cin.
  - Go to RUN.
- RUN, one nibble per edge, slice i = low nibble of the shift registers. Conditioning per op (x, y, cin):
  - ADD: x=Ai, y=Bi, cin=0.
  - SUB: x=Ai, y=~Bi, cin=1.
  - INC: x=Ai, y=0000, cin=1.
  - NEG: x=0000, y=~Ai, cin=1.
  - cin applies to nibble 0 only. Higher nibbles use the carry registered from the previous nibble.
- Per-nibble arithmetic:
  - s = x + y + c, computed 5 bits wide. s[3:0] shifts into the top of the result accumulator. s[4] becomes the next c.
  - Operand registers shift right by 4.
- On the last nibble (counter = NIB−1):
  - cout = s[4].
  - ovf = (x[3]==y[3]) & (s[3]!=x[3]), computed from the conditioned top-nibble operands.
  - Load result from the completed accumulator; zero = (completed result == 0).
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- Output holding:
  - result and flags are registered; they update only on the RUN→DONE edge.
  - They hold their values until the next completed operation, so intermediate partial sums are never visible on result.
- start while busy (RUN) or in DONE is ignored; it is not queued.
- Reset asserted mid-RUN: the operation is aborted and outputs return to their reset values. No done pulse follows reset release.

## Timing
- Accepted start at edge k:
  - busy=1 from after edge k through edge k+NIB.
  - done=1 during the cycle after edge k+NIB.
  - Back in IDLE after edge k+NIB+1.
- Latency: start to done = NIB+1 cycles. Throughput: one operation per NIB+2 cycles when start is held high continuously.
- busy and done are never high in the same cycle. done is low in IDLE and RUN.
- a, b and op may change freely after the accepting edge.

## Test plan
All cases use NIB=4.
- Reset value check: apply reset, release, hold start=0 for 10 cycles -> busy=0, done=0, result=0x0000, all flags 0.
- ADD: a=0x1234, b=0x0FCC -> done exactly 5 cycles after start; result=0x2200, cout=0, ovf=0, zero=0. Then ADD a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1, cout=0.
- SUB: a=0x0005, b=0x0007 -> result=0xFFFE, cout=0, ovf=0. Then SUB a=0x8000, b=0x0001 -> result=0x7FFF, ovf=1, cout=1.
- INC/NEG:
  - INC a=0xFFFF -> result=0x0000, cout=1, zero=1.
  - NEG a=0x8000 -> result=0x8000, ovf=1, cout=0.
  - NEG a=0x0000 -> result=0x0000, cout=1, zero=1.
- Handshake: pulse start again at cycles 2 and 4 of a RUN with different operands -> ignored, first result unchanged. With start held high -> back-to-back results every 6 cycles, one done pulse each.
- Reset mid-operation: assert reset after 2 RUN cycles of ADD 0x1111+0x1111 -> outputs cleared immediately, no done after release. A subsequent ADD 0x0001+0x0001 -> result=0x0002.

Source files
------------

// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: wide add/sub/inc/neg sequencer that streams 4-bit slices,
// least-significant nibble first, through a conditioned 4-bit adder with the
// carry chained between slices. Results and flags are registered and only
// change when an operation completes.
`timescale 1ns/1ps
module nibble_serial_alu #(
    parameter  int NIB = 4,
    localparam int W   = 4 * NIB
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] result_o,
    output logic         cout_o,
    output logic         zero_o,
    output logic         ovf_o
);

    localparam int CW = $clog2(NIB);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_INC = 2'b10;
    localparam logic [1:0] OP_NEG = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    // Operand shift registers: the active slice is always the low nibble.
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [1:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    // Holds the NIB-1 lower result nibbles; the last sum nibble completes it.
    logic [W-5:0]  acc_q, acc_d;

    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;

    logic [3:0]    x_nib;
    logic [3:0]    y_nib;
    logic [4:0]    sum;
    logic          last_nib;
    logic [W-1:0]  full_res;

    assign last_nib = (cnt_q == CW'(NIB - 1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE, DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_nib) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            S_RUN:   busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Operand conditioning and 5-bit slice adder for the current nibble.
    always_comb begin
        x_nib = a_sh_q[3:0];
        y_nib = b_sh_q[3:0];
        case (op_q)
            OP_ADD: begin
                x_nib = a_sh_q[3:0];
                y_nib = b_sh_q[3:0];
            end
            OP_SUB: begin
                x_nib = a_sh_q[3:0];
                y_nib = ~b_sh_q[3:0];
            end
            OP_INC: begin
                x_nib = a_sh_q[3:0];
                y_nib = 4'b0000;
            end
            OP_NEG: begin
                x_nib = 4'b0000;
                y_nib = ~a_sh_q[3:0];
            end
            default: ;
        endcase
        sum      = {1'b0, x_nib} + {1'b0, y_nib} + {4'b0000, carry_q};
        full_res = {sum[3:0], acc_q};
    end

    // Datapath next state: load on accept, shift one nibble per RUN cycle,
    // publish result and flags only when the top nibble is processed.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    op_d    = op_i;
                    cnt_d   = '0;
                    // Only ADD starts without an injected carry.
                    carry_d = (op_i != OP_ADD);
                end
            end
            S_RUN: begin
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                cnt_d   = cnt_q + CW'(1);
                carry_d = sum[4];
                acc_d   = full_res[W-1:4];
                if (last_nib) begin
                    result_d = full_res;
                    cout_d   = sum[4];
                    zero_d   = (full_res == '0);
                    ovf_d    = (x_nib[3] == y_nib[3]) & (sum[3] != x_nib[3]);
                end
            end
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result_o = result_q;
    assign cout_o   = cout_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Testbench for nibble_serial_alu (NIB=4): directed cases, start-while-busy,
// back-to-back throughput, mid-operation reset and randomized operations
// checked against a whole-word arithmetic reference model.
`timescale 1ns/1ps
module tb_nibble_serial_alu;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         cout_o;
    logic         zero_o;
    logic         ovf_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done_cyc = -1;

    nibble_serial_alu #(.NIB(NIB)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .cout_o   (cout_o),
        .zero_o   (zero_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word two's-complement arithmetic, flags from sign rules.
    // Returns {cout, zero, ovf, result}.
    function automatic logic [W+2:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         ov;
        full = '0;
        ov   = 1'b0;
        case (op)
            2'b00: full = {1'b0, a} + {1'b0, b};
            2'b01: full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            2'b10: full = {1'b0, a} + (W+1)'(1);
            default: full = {1'b0, ~a} + (W+1)'(1);
        endcase
        r = full[W-1:0];
        case (op)
            2'b00: ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            2'b01: ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            2'b10: ov = (a == {1'b0, {(W-1){1'b1}}});
            default: ov = (a == {1'b1, {(W-1){1'b0}}});
        endcase
        return {full[W], (r == '0), ov, r};
    endfunction

    // One operation from IDLE: accept, wait for done (bounded), check outputs.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic exp_c, input logic exp_z,
                          input logic exp_v, input bit noise, input bit hold);
        logic [W-1:0] prev;
        int n;
        prev    = result_o;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i); #1;
        check("accept_busy", busy_o, 1);
        check("accept_done", done_o, 0);
        if (!hold) begin
            start_i = 1'b0;
            op_i    = 2'($urandom);
            a_i     = W'($urandom);
            b_i     = W'($urandom);
        end
        n = 0;
        while (!done_o && n < 20) begin
            if (noise) begin
                start_i = (n == 1 || n == 3);
                op_i    = 2'($urandom);
                a_i     = W'($urandom);
                b_i     = W'($urandom);
            end
            check("result_held", result_o, prev);
            @(posedge clk_i); #1;
            n++;
            check("busy_done_excl", busy_o & done_o, 0);
        end
        if (noise) start_i = 1'b0;
        check("latency", n, NIB);
        check("result", result_o, exp_res);
        check("cout", cout_o, exp_c);
        check("zero", zero_o, exp_z);
        check("ovf", ovf_o, exp_v);
        if (hold) begin
            if (last_done_cyc >= 0) check("period", cyc - last_done_cyc, NIB + 2);
            last_done_cyc = cyc;
        end
        $display("op=%0d a=%h b=%h -> result=%h cout=%b zero=%b ovf=%b lat=%0d",
                 op, a, b, result_o, cout_o, zero_o, ovf_o, n);
        @(posedge clk_i); #1;
        check("idle_done", done_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_result", result_o, exp_res);
    endtask

    task automatic run_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit hold);
        logic [W+2:0] m;
        m = model(op, a, b);
        run_op(op, a, b, m[W-1:0], m[W+2], m[W+1], m[W], 1'b0, hold);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        op_i    = 2'b00;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_result", result_o, 0);
        check("rst_cout", cout_o, 0);
        check("rst_zero", zero_o, 0);
        check("rst_ovf", ovf_o, 0);
        $display("reset: busy=%b done=%b result=%h", busy_o, done_o, result_o);

        // Directed cases with hand-derived expectations.
        run_op(2'b00, 16'h1234, 16'h0FCC, 16'h2200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2'b01, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2'b10, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op(2'b11, 16'h8000, 16'h5555, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(2'b11, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // start pulsed during RUN with other operands must be ignored.
        run_op(2'b00, 16'h1234, 16'h0FCC, 16'h2200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // start held high: back-to-back operations every NIB+2 cycles.
        last_done_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            run_model(2'($urandom), W'($urandom), W'($urandom), 1'b1);
        end
        start_i = 1'b0;
        @(posedge clk_i); #1;
        check("after_hold_busy", busy_o, 0);

        // Mid-operation reset.
        run_op(2'b11, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        start_i = 1'b1;
        op_i    = 2'b00;
        a_i     = 16'h1111;
        b_i     = 16'h1111;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check("midrst_result", result_o, 0);
        check("midrst_ovf", ovf_o, 0);
        $display("mid-run reset: busy=%b result=%h ovf=%b", busy_o, result_o, ovf_o);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            check("post_rst_no_done", done_o, 0);
        end
        check("post_rst_result", result_o, 0);
        run_op(2'b00, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rb = 16'h7FFF;
            if (i % 8 == 2) ra = 16'hFFFF;
            run_model(2'($urandom_range(0, 3)), ra, rb, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
